// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-side bundle for the round-robin FIFO write arbiter
interface fifo_wr_arbiter_if #(
    parameter int B = 8
) ();
    logic [3:0]     req;
    logic [4*B-1:0] din;
    logic [3:0]     ack;
    logic           fifo_full;
    logic           fifo_wr;
    logic [B-1:0]   fifo_wr_data;
    logic [1:0]     gnt_id;
    logic           busy;

    modport slave (
        input  req,
        input  din,
        input  fifo_full,
        output ack,
        output fifo_wr,
        output fifo_wr_data,
        output gnt_id,
        output busy
    );

    modport master (
        output req,
        output din,
        output fifo_full,
        input  ack,
        input  fifo_wr,
        input  fifo_wr_data,
        input  gnt_id,
        input  busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - four-requester round-robin arbiter feeding one FIFO write port in bursts
module fifo_wr_arbiter #(
    parameter int B         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    fifo_wr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // cnt is compared against the index of the final transfer of a burst
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q,  last_d;
    logic [3:0] cnt_q,   cnt_d;

    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;
    logic       wr;
    logic [1:0] gnt_id;
    logic [B-1:0] wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Search starts one past the last owner so the previous winner ranks lowest
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        wr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req != 4'd0) begin
                    state_d = GRANT;
                    owner_d = winner;
                    cnt_d   = 4'd0;
                end
            end
            GRANT: begin
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (!bus.fifo_full) begin
                    wr    = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == BURST_LAST) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_id = (state_q == GRANT) ? owner_q : last_q;

    // Data follows gnt_id unconditionally so the FIFO sees a stable word even while stalled
    always_comb begin
        wr_data = '0;
        for (int k = 0; k < 4; k++) begin
            if (gnt_id == 2'(k)) begin
                wr_data = bus.din[k*B +: B];
            end
        end
    end

    assign bus.fifo_wr      = wr;
    assign bus.ack          = wr ? (4'b0001 << owner_q) : 4'b0000;
    assign bus.gnt_id       = gnt_id;
    assign bus.busy         = (state_q == GRANT);
    assign bus.fifo_wr_data = wr_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int B = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.B(B)) bus0 ();
    fifo_wr_arbiter_if #(.B(B)) bus1 ();

    fifo_wr_arbiter #(.B(B), .MAX_BURST(4)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    fifo_wr_arbiter #(.B(B), .MAX_BURST(1)) u1 (.clk(clk), .reset(reset), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // {fifo_wr, ack, busy, gnt_id, fifo_wr_data}
    wire [15:0] obs0 = {bus0.fifo_wr, bus0.ack, bus0.busy, bus0.gnt_id, bus0.fifo_wr_data};
    wire [15:0] obs1 = {bus1.fifo_wr, bus1.ack, bus1.busy, bus1.gnt_id, bus1.fifo_wr_data};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus0.req       = 4'd0;
        bus1.req       = 4'd0;
        bus0.fifo_full = 1'b0;
        bus1.fifo_full = 1'b0;
        bus0.din       = {8'h33, 8'h22, 8'h11, 8'h00};
        bus1.din       = {8'h33, 8'h22, 8'h11, 8'h00};
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        reset          = 1'b1;
        bus0.req       = 4'b1111;
        bus1.req       = 4'b1111;
        bus0.fifo_full = 1'b0;
        bus1.fifo_full = 1'b0;
        bus0.din       = {8'h33, 8'h22, 8'h11, 8'h00};
        bus1.din       = {8'h33, 8'h22, 8'h11, 8'h00};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            exp = {1'b0, 4'b0000, 1'b0, 2'd3, 8'h33};
            checks++;
            if (obs0 !== exp) begin
                errors++;
                $display("FAIL reset0 cyc%0d got %h want %h", c, obs0, exp);
            end
            checks++;
            if (obs1 !== exp) begin
                errors++;
                $display("FAIL reset1 cyc%0d got %h want %h", c, obs1, exp);
            end
        end
        next_cycle();
    endtask

    task automatic test_single();
        logic [7:0]  d0_tab [7] = '{8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA4};
        logic        wr_tab [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]  g;
        logic [15:0] exp;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            exp = {1'b0, 4'b0000, 1'b0, 2'd3, 8'h33};
            checks++;
            if (obs0 !== exp) begin
                errors++;
                $display("FAIL single_idle cyc%0d got %h want %h", c, obs0, exp);
            end
            next_cycle();
        end
        bus0.req = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            bus0.din[7:0] = d0_tab[c];
            @(negedge clk);
            g   = (c == 0) ? 2'd3 : 2'd0;
            exp = {wr_tab[c], wr_tab[c] ? 4'b0001 : 4'b0000, wr_tab[c], g,
                   (g == 2'd3) ? 8'h33 : d0_tab[c]};
            checks++;
            if (obs0 !== exp) begin
                errors++;
                $display("FAIL single cyc%0d got %h want %h", c, obs0, exp);
            end
            next_cycle();
        end
        bus0.req = 4'b0000;
        @(negedge clk);
        exp = {1'b0, 4'b0000, 1'b1, 2'd0, 8'hA4};
        checks++;
        if (obs0 !== exp) begin
            errors++;
            $display("FAIL single_drop got %h want %h", obs0, exp);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]  g;
        logic        wr;
        logic [15:0] exp;
        do_reset();
        bus0.req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (c % 5 == 0) begin
                g  = (c == 0) ? 2'd3 : 2'((c / 5) - 1);
                wr = 1'b0;
            end else begin
                g  = 2'(c / 5);
                wr = 1'b1;
            end
            exp = {wr, wr ? (4'b0001 << g) : 4'b0000, wr, g, 8'h11 * {6'd0, g}};
            checks++;
            if (obs0 !== exp) begin
                errors++;
                $display("FAIL round_robin cyc%0d got %h want %h", c, obs0, exp);
            end
            next_cycle();
        end
        bus0.req = 4'b0000;
        next_cycle();
    endtask

    task automatic test_stall();
        logic        full_tab [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic        wr_tab   [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        logic        busy_tab [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [1:0]  g;
        logic [15:0] exp;
        do_reset();
        bus0.req = 4'b0100;
        for (int c = 0; c < 9; c++) begin
            bus0.fifo_full = full_tab[c];
            @(negedge clk);
            g   = (c == 0) ? 2'd3 : 2'd2;
            exp = {wr_tab[c], wr_tab[c] ? 4'b0100 : 4'b0000, busy_tab[c], g,
                   8'h11 * {6'd0, g}};
            checks++;
            if (obs0 !== exp) begin
                errors++;
                $display("FAIL stall cyc%0d got %h want %h", c, obs0, exp);
            end
            next_cycle();
        end
        bus0.req       = 4'b0000;
        bus0.fifo_full = 1'b0;
        next_cycle();
    endtask

    task automatic test_drop();
        logic [3:0]  req_tab [5] = '{4'b0010, 4'b0010, 4'b1001, 4'b1001, 4'b1001};
        logic [15:0] exp_tab [5];
        exp_tab[0] = {1'b0, 4'b0000, 1'b0, 2'd3, 8'h33};
        exp_tab[1] = {1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
        exp_tab[2] = {1'b0, 4'b0000, 1'b1, 2'd1, 8'h11};
        exp_tab[3] = {1'b0, 4'b0000, 1'b0, 2'd1, 8'h11};
        exp_tab[4] = {1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus0.req = req_tab[c];
            @(negedge clk);
            checks++;
            if (obs0 !== exp_tab[c]) begin
                errors++;
                $display("FAIL drop cyc%0d got %h want %h", c, obs0, exp_tab[c]);
            end
            next_cycle();
        end
        bus0.req = 4'b0000;
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] exp;
        do_reset();
        bus0.req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp = (c == 0) ? {1'b0, 4'b0000, 1'b0, 2'd3, 8'h33}
                           : {1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
            checks++;
            if (obs0 !== exp) begin
                errors++;
                $display("FAIL midrst_pre cyc%0d got %h want %h", c, obs0, exp);
            end
            next_cycle();
        end
        #1;
        reset = 1'b1;
        #1;
        exp = {1'b0, 4'b0000, 1'b0, 2'd3, 8'h33};
        checks++;
        if (obs0 !== exp) begin
            errors++;
            $display("FAIL midrst_async got %h want %h", obs0, exp);
        end
        @(negedge clk);
        checks++;
        if (obs0 !== exp) begin
            errors++;
            $display("FAIL midrst_hold got %h want %h", obs0, exp);
        end
        next_cycle();
        reset    = 1'b0;
        bus0.req = 4'b1111;
        @(negedge clk);
        checks++;
        if (obs0 !== exp) begin
            errors++;
            $display("FAIL midrst_arb got %h want %h", obs0, exp);
        end
        next_cycle();
        @(negedge clk);
        exp = {1'b1, 4'b0001, 1'b1, 2'd0, 8'h00};
        checks++;
        if (obs0 !== exp) begin
            errors++;
            $display("FAIL midrst_grant got %h want %h", obs0, exp);
        end
        next_cycle();
        bus0.req = 4'b0000;
        next_cycle();
    endtask

    task automatic test_burst_one();
        logic [1:0]  g;
        logic        wr;
        logic [15:0] exp;
        do_reset();
        bus1.req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            wr = (c % 2 == 1);
            if (c == 0)
                g = 2'd3;
            else if (wr)
                g = 2'((c >> 1) & 1);
            else
                g = 2'(((c >> 1) - 1) & 1);
            exp = {wr, wr ? (4'b0001 << g) : 4'b0000, wr, g, 8'h11 * {6'd0, g}};
            checks++;
            if (obs1 !== exp) begin
                errors++;
                $display("FAIL burst_one cyc%0d got %h want %h", c, obs1, exp);
            end
            next_cycle();
        end
        bus1.req = 4'b0000;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_drop();
        test_reset_mid_burst();
        test_burst_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
